// File: rtl/dtim_banked.sv
// dtim_banked -- banked, dual-requester tightly integrated data memory.
//
// The DTIM is split into NBANKS word-interleaved banks. The LSU port has
// priority; an external valid/ready port (DMA/debug) shares the banks and
// wins a bank conflict only after STARVE_MAX consecutive denials.
//
// Parameters
//   P          : core configuration (uses LLEN, PA_BITS, DTIM_RANGE)
//   NBANKS     : bank count, power of two, >= 1
//   STARVE_MAX : consecutive external denials before the external port wins
//
// Optional feature macro: DTIM_PARITY_EN
//   defined   : one even-parity bit per byte, checked on every read
//   undefined : no parity storage, ParityErrM/ExtRErr tied to 0
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   FlushW         : suppresses the LSU write
//   ce, MemRWM     : LSU enable and read[1]/write[0] request
//   DTIMAdr        : LSU address
//   WriteDataM     : LSU write data
//   ByteMaskM      : LSU byte write enables
//   ReadDataWordM  : LSU read data, one cycle after the request, held otherwise
//   DTIMStall      : LSU request denied this cycle
//   ExtValid/Ready : external request handshake
//   ExtWrite       : external write (1) / read (0)
//   ExtAdr         : external address
//   ExtWData       : external write data
//   ExtBMask       : external byte write enables
//   ExtRValid      : external read data valid (one cycle per accepted read)
//   ExtRData       : external read data
//   ParityErrM     : parity error flag alongside ReadDataWordM
//   ExtRErr        : parity error flag alongside ExtRData

package dtim_banked_pkg;
    // Subset of the core configuration struct that this block consumes.
    typedef struct packed {
        int LLEN;
        int PA_BITS;
        int DTIM_RANGE;
    } cvw_t;

    localparam cvw_t DTIM_DEFAULT_CFG = '{LLEN: 64, PA_BITS: 32, DTIM_RANGE: 256};
endpackage

module dtim_banked
    import dtim_banked_pkg::*;
#(
    parameter cvw_t P          = DTIM_DEFAULT_CFG,
    parameter int   NBANKS     = 2,
    parameter int   STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   FlushW,
    input  logic                   ce,
    input  logic [1:0]             MemRWM,
    input  logic [P.PA_BITS-1:0]   DTIMAdr,
    input  logic [P.LLEN-1:0]      WriteDataM,
    input  logic [P.LLEN/8-1:0]    ByteMaskM,
    output logic [P.LLEN-1:0]      ReadDataWordM,
    output logic                   DTIMStall,
    input  logic                   ExtValid,
    output logic                   ExtReady,
    input  logic                   ExtWrite,
    input  logic [P.PA_BITS-1:0]   ExtAdr,
    input  logic [P.LLEN-1:0]      ExtWData,
    input  logic [P.LLEN/8-1:0]    ExtBMask,
    output logic                   ExtRValid,
    output logic [P.LLEN-1:0]      ExtRData,
    output logic                   ParityErrM,
    output logic                   ExtRErr
);

    localparam int BYTES  = P.LLEN / 8;
    localparam int OFFSET = $clog2(BYTES);
    localparam int DEPTH  = P.DTIM_RANGE / BYTES;
    localparam int ROWS   = DEPTH / NBANKS;
    localparam int BB     = $clog2(NBANKS);
    localparam int BW     = (BB > 0) ? BB : 1;
    localparam int RB     = $clog2(ROWS);
    localparam int RW     = (RB > 0) ? RB : 1;
    localparam int SB     = $clog2(STARVE_MAX + 1);
    localparam int SW     = (SB > 0) ? SB : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    function automatic logic [BW-1:0] bank_of(input logic [P.PA_BITS-1:0] a);
        return (NBANKS > 1) ? a[OFFSET +: BW] : '0;
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [P.PA_BITS-1:0] a);
        return (ROWS > 1) ? a[OFFSET + BB +: RW] : '0;
    endfunction

    logic [BW-1:0] lbank, ebank;
    logic [RW-1:0] lrow, erow;
    logic          lreq, ereq, samebank, at_max;
    logic          lsu_go, lsu_we, lsu_re;
    logic          ext_go, ext_we, ext_re;
    logic [SW-1:0] starve;
    logic          ext_rvalid_q;
    logic          unused_adr;

    assign lbank = bank_of(DTIMAdr);
    assign ebank = bank_of(ExtAdr);
    assign lrow  = row_of(DTIMAdr);
    assign erow  = row_of(ExtAdr);
    // Address bits above the row field do not select anything.
    assign unused_adr = ^{DTIMAdr, ExtAdr};

    assign lreq     = ce & |MemRWM;
    assign ereq     = ExtValid;
    assign samebank = (lbank == ebank);
    assign at_max   = (starve == SMAX);

    // Handshake: an external request transfers on a cycle where ExtValid and
    // ExtReady are both high; ExtValid and its payload hold until then.
    // ExtReady is evaluated as if ExtValid were high, so it never depends
    // combinationally on ExtValid. Read responses come back one cycle later,
    // in order, with no backpressure.
    assign ExtReady  = ~reset & ~(lreq & samebank & ~at_max);
    assign DTIMStall = ~reset & lreq & ereq & samebank & at_max;

    assign ext_go = ereq & ExtReady;
    assign ext_we = ext_go & ExtWrite;
    assign ext_re = ext_go & ~ExtWrite;
    assign lsu_go = lreq & ~DTIMStall & ~reset;
    assign lsu_we = lsu_go & MemRWM[0] & ~FlushW;
    assign lsu_re = lsu_go & MemRWM[1];

    logic [P.LLEN-1:0] lbank_rd [NBANKS];
    logic [P.LLEN-1:0] ebank_rd [NBANKS];
`ifdef DTIM_PARITY_EN
    logic [BYTES-1:0]  lbank_par [NBANKS];
    logic [BYTES-1:0]  ebank_par [NBANKS];

    function automatic logic [BYTES-1:0] byte_par(input logic [P.LLEN-1:0] d);
        logic [BYTES-1:0] p;
        p = '0;
        for (int b = 0; b < BYTES; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction
`endif

    // A port only touches a bank it targets and was granted; arbitration
    // guarantees the two ports never write the same bank in one cycle.
    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        logic [P.LLEN-1:0] ram [ROWS];
        logic              lsel, esel;

        assign lsel = (lbank == BW'(g));
        assign esel = (ebank == BW'(g));

        always_ff @(posedge clk) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lsu_we && lsel && ByteMaskM[b]) ram[lrow][8*b +: 8] <= WriteDataM[8*b +: 8];
                if (ext_we && esel && ExtBMask[b])  ram[erow][8*b +: 8] <= ExtWData[8*b +: 8];
            end
        end

        assign lbank_rd[g] = ram[lrow];
        assign ebank_rd[g] = ram[erow];

`ifdef DTIM_PARITY_EN
        logic [BYTES-1:0] par [ROWS];

        always_ff @(posedge clk) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lsu_we && lsel && ByteMaskM[b]) par[lrow][b] <= ^WriteDataM[8*b +: 8];
                if (ext_we && esel && ExtBMask[b])  par[erow][b] <= ^ExtWData[8*b +: 8];
            end
        end

        assign lbank_par[g] = par[lrow];
        assign ebank_par[g] = par[erow];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataWordM <= '0;
            ExtRData      <= '0;
            ext_rvalid_q  <= 1'b0;
            starve        <= '0;
        end else begin
            if (lsu_re) ReadDataWordM <= lbank_rd[lbank];
            if (ext_re) ExtRData <= ebank_rd[ebank];
            ext_rvalid_q <= ext_re;
            if (ext_go)
                starve <= '0;
            else if (ExtValid && !ExtReady && !at_max)
                starve <= starve + 1'b1;
        end
    end

    // A response registered just before reset rises is dropped immediately.
    assign ExtRValid = ext_rvalid_q & ~reset;

`ifdef DTIM_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ParityErrM <= 1'b0;
            ExtRErr    <= 1'b0;
        end else begin
            if (lsu_re) ParityErrM <= |(lbank_par[lbank] ^ byte_par(lbank_rd[lbank]));
            if (ext_re) ExtRErr    <= |(ebank_par[ebank] ^ byte_par(ebank_rd[ebank]));
        end
    end
`else
    assign ParityErrM = 1'b0;
    assign ExtRErr    = 1'b0;
`endif

endmodule
